// File: rtl/axi_pkg.sv
// AXI4 channel bundles: host-to-device (requests) and device-to-host (responses).
package axi_pkg;
    typedef struct packed {
        logic [top_pkg::AXI_IW-1:0]   awid;
        logic [top_pkg::AXI_AW-1:0]   awaddr;
        logic [7:0]                   awlen;
        logic [2:0]                   awsize;
        logic [1:0]                   awburst;
        logic                         awvalid;
        logic [top_pkg::AXI_DW-1:0]   wdata;
        logic [top_pkg::AXI_DW/8-1:0] wstrb;
        logic                         wlast;
        logic                         wvalid;
        logic                         bready;
        logic [top_pkg::AXI_IW-1:0]   arid;
        logic [top_pkg::AXI_AW-1:0]   araddr;
        logic [7:0]                   arlen;
        logic [2:0]                   arsize;
        logic [1:0]                   arburst;
        logic                         arvalid;
        logic                         rready;
    } axi_h2d_t;

    typedef struct packed {
        logic                         awready;
        logic                         wready;
        logic [top_pkg::AXI_IW-1:0]   bid;
        logic [1:0]                   bresp;
        logic                         bvalid;
        logic                         arready;
        logic [top_pkg::AXI_IW-1:0]   rid;
        logic [top_pkg::AXI_DW-1:0]   rdata;
        logic [1:0]                   rresp;
        logic                         rlast;
        logic                         rvalid;
    } axi_d2h_t;
endpackage

// File: rtl/axi_stream_read_responder_pkg.sv
// Shared types for the stream-backed AXI read responder.
package axi_stream_read_responder_pkg;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAD} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One buffered stream beat: end-of-packet flag plus payload.
    typedef struct packed {
        logic                       last;
        logic [top_pkg::AXI_DW-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/top_pkg.sv
// Project-wide AXI bus dimensions shared by every block on the system bus.
package top_pkg;
    localparam int AXI_DW = 32;
    localparam int AXI_IW = 4;
    localparam int AXI_AW = 32;
endpackage

// File: rtl/stream_fifo_sync.sv
// Synchronous first-word-fall-through FIFO; head entry is visible while non-empty.
module stream_fifo_sync #(
    parameter int Depth = 16,
    parameter int Width = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_reg [Depth];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (level_reg == (AW+1)'(Depth));
    assign empty     = (level_reg == '0);
    assign level     = level_reg;
    assign head_data = mem_reg[rd_ptr_reg];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Storage array is not reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      level_reg <= level_reg + 1'b1;
            else if (do_pop && !do_push) level_reg <= level_reg - 1'b1;
        end
    end
endmodule

// File: rtl/axi_stream_read_responder.sv
// AXI4 slave answering AR bursts from a buffered AXI-Stream; writes are drained
// and answered with SLVERR. Optional macro AXI_RD_RESP_STATS_EN builds the
// R-beat counter on beat_count_o (tied to zero otherwise).
module axi_stream_read_responder
    import axi_stream_read_responder_pkg::*;
#(
    parameter int FifoDepth = 16,
    parameter int DataWidth = top_pkg::AXI_DW,
    parameter int IdWidth   = top_pkg::AXI_IW
) (
    input  logic                         clock,
    input  logic                         reset,
    input  axi_pkg::axi_h2d_t            axi_i,
    output axi_pkg::axi_d2h_t            axi_o,
    input  logic [DataWidth-1:0]         s_tdata_i,
    input  logic                         s_tvalid_i,
    output logic                         s_tready_o,
    input  logic                         s_tlast_i,
    output logic [$clog2(FifoDepth):0]   fifo_level_o,
    output logic [31:0]                  beat_count_o
);
    rd_state_e          rd_state_reg;
    wr_state_e          wr_state_reg;
    logic [IdWidth-1:0] rd_id_reg;
    logic [IdWidth-1:0] wr_id_reg;
    logic [7:0]         rd_len_reg;
    logic [7:0]         rd_cnt_reg;

    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               r_hs;
    logic               unused_axi;

    // Address/size/burst and write payload carry no meaning for this responder.
    assign unused_axi = ^{axi_i.awaddr, axi_i.awlen, axi_i.awsize, axi_i.awburst,
                          axi_i.wdata, axi_i.wstrb, axi_i.araddr, axi_i.arsize,
                          axi_i.arburst};

    assign push_entry = '{last: s_tlast_i, data: s_tdata_i};
    assign s_tready_o = !reset && !fifo_full;
    assign fifo_pop   = (rd_state_reg == R_DATA) && !fifo_empty && axi_i.rready;
    assign r_hs       = axi_o.rvalid && axi_i.rready;

    stream_fifo_sync #(
        .Depth (FifoDepth),
        .Width ($bits(fifo_entry_t))
    ) u_fifo (
        .clk       (clock),
        .srst      (reset),
        .push      (s_tvalid_i && s_tready_o),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level_o)
    );

    // Read FSM: stream data until the packet ends, then pad with SLVERR beats.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_reg <= R_IDLE;
            rd_id_reg    <= '0;
            rd_len_reg   <= '0;
            rd_cnt_reg   <= '0;
        end else begin
            case (rd_state_reg)
                R_IDLE: if (axi_i.arvalid) begin
                    rd_id_reg    <= axi_i.arid;
                    rd_len_reg   <= axi_i.arlen;
                    rd_cnt_reg   <= '0;
                    rd_state_reg <= R_DATA;
                end
                R_DATA: if (fifo_pop) begin
                    rd_cnt_reg <= rd_cnt_reg + 8'd1;
                    if (rd_cnt_reg == rd_len_reg) rd_state_reg <= R_IDLE;
                    else if (head_entry.last)     rd_state_reg <= R_PAD;
                end
                R_PAD: if (axi_i.rready) begin
                    rd_cnt_reg <= rd_cnt_reg + 8'd1;
                    if (rd_cnt_reg == rd_len_reg) rd_state_reg <= R_IDLE;
                end
                default: rd_state_reg <= R_IDLE;
            endcase
        end
    end

    // Write FSM: accept the address, swallow the data, answer SLVERR.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_reg <= W_IDLE;
            wr_id_reg    <= '0;
        end else begin
            case (wr_state_reg)
                W_IDLE: if (axi_i.awvalid) begin
                    wr_id_reg    <= axi_i.awid;
                    wr_state_reg <= W_DATA;
                end
                W_DATA: if (axi_i.wvalid && axi_i.wlast) wr_state_reg <= W_RESP;
                W_RESP: if (axi_i.bready) wr_state_reg <= W_IDLE;
                default: wr_state_reg <= W_IDLE;
            endcase
        end
    end

    // Channel outputs decode straight from state registers and the FIFO head.
    always_comb begin
        axi_o         = '0;
        axi_o.arready = (rd_state_reg == R_IDLE);
        axi_o.awready = (wr_state_reg == W_IDLE);
        axi_o.wready  = (wr_state_reg == W_DATA);
        axi_o.bvalid  = (wr_state_reg == W_RESP);
        axi_o.bresp   = (wr_state_reg == W_RESP) ? RESP_SLVERR : RESP_OKAY;
        axi_o.bid     = wr_id_reg;
        axi_o.rid     = rd_id_reg;
        case (rd_state_reg)
            R_DATA: begin
                axi_o.rvalid = !fifo_empty;
                axi_o.rdata  = fifo_empty ? '0 : head_entry.data;
                axi_o.rresp  = RESP_OKAY;
                axi_o.rlast  = (rd_cnt_reg == rd_len_reg);
            end
            R_PAD: begin
                axi_o.rvalid = 1'b1;
                axi_o.rresp  = RESP_SLVERR;
                axi_o.rlast  = (rd_cnt_reg == rd_len_reg);
            end
            default: ;
        endcase
    end

`ifdef AXI_RD_RESP_STATS_EN
    logic [31:0] beat_count_reg;

    // Counts every R handshake, padding included; wraps at 2^32.
    always_ff @(posedge clock) begin
        if (reset)     beat_count_reg <= '0;
        else if (r_hs) beat_count_reg <= beat_count_reg + 32'd1;
    end

    assign beat_count_o = beat_count_reg;
`else
    logic unused_r_hs;
    assign unused_r_hs  = r_hs;
    assign beat_count_o = '0;
`endif
endmodule

// File: tb/tb_axi_stream_read_responder.sv
// Directed bench for axi_stream_read_responder: bursts, padding, backpressure,
// starvation, FIFO full, write rejection and reset mid-burst.
module tb_axi_stream_read_responder;
    import axi_stream_read_responder_pkg::*;

`ifdef AXI_RD_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    axi_pkg::axi_h2d_t axi_i;
    axi_pkg::axi_d2h_t axi_o;
    logic [31:0]       s_tdata_i;
    logic              s_tvalid_i;
    logic              s_tready_o;
    logic              s_tlast_i;
    logic [4:0]        fifo_level_o;
    logic [31:0]       beat_count_o;

    int checks = 0;
    int errors = 0;
    int exp_beats = 0;

    axi_stream_read_responder dut (
        .clock        (clock),
        .reset        (reset),
        .axi_i        (axi_i),
        .axi_o        (axi_o),
        .s_tdata_i    (s_tdata_i),
        .s_tvalid_i   (s_tvalid_i),
        .s_tready_o   (s_tready_o),
        .s_tlast_i    (s_tlast_i),
        .fifo_level_o (fifo_level_o),
        .beat_count_o (beat_count_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        s_tvalid_i = 1'b1;
        s_tdata_i  = d;
        s_tlast_i  = last;
        tick();
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
    endtask

    task automatic ar(input logic [3:0] id, input logic [7:0] len);
        axi_i.arvalid = 1'b1;
        axi_i.arid    = id;
        axi_i.arlen   = len;
        tick();
        axi_i.arvalid = 1'b0;
    endtask

    // Checks the beat currently presented, then lets it complete with rready=1.
    task automatic beat(input string tag, input logic [31:0] d, input logic [1:0] resp,
                        input logic [3:0] id, input logic last);
        chk({tag, "_rvalid"}, 64'(axi_o.rvalid), 64'd1);
        chk({tag, "_rdata"},  64'(axi_o.rdata),  64'(d));
        chk({tag, "_rresp"},  64'(axi_o.rresp),  64'(resp));
        chk({tag, "_rid"},    64'(axi_o.rid),    64'(id));
        chk({tag, "_rlast"},  64'(axi_o.rlast),  64'(last));
        $display("beat %s: rdata=%0h rresp=%0d rid=%0d rlast=%0d", tag, axi_o.rdata,
                 axi_o.rresp, axi_o.rid, axi_o.rlast);
        axi_i.rready = 1'b1;
        exp_beats++;
        tick();
    endtask

    task automatic chk_beats(input string tag);
        chk(tag, 64'(beat_count_o), STATS ? 64'(exp_beats) : 64'd0);
    endtask

    initial begin
        axi_i      = '0;
        reset      = 1'b1;
        s_tdata_i  = '0;
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        tick();
        tick();
        chk("rst_arready", 64'(axi_o.arready), 64'd1);
        chk("rst_awready", 64'(axi_o.awready), 64'd1);
        chk("rst_wready",  64'(axi_o.wready),  64'd0);
        chk("rst_rvalid",  64'(axi_o.rvalid),  64'd0);
        chk("rst_bvalid",  64'(axi_o.bvalid),  64'd0);
        chk("rst_tready",  64'(s_tready_o),    64'd0);
        chk("rst_level",   64'(fifo_level_o),  64'd0);
        chk("rst_beats",   64'(beat_count_o),  64'd0);
        reset = 1'b0;
        tick();
        chk("tready_after_rst", 64'(s_tready_o), 64'd1);

        // Basic burst: 4 words, first beat right after AR.
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i), i == 3);
        chk("basic_level", 64'(fifo_level_o), 64'd4);
        axi_i.rready = 1'b1;
        ar(4'd3, 8'd3);
        for (int i = 0; i < 4; i++) beat($sformatf("basic%0d", i), 32'hA0 + 32'(i), RESP_OKAY, 4'd3, i == 3);
        chk("basic_rvalid_end", 64'(axi_o.rvalid),  64'd0);
        chk("basic_arready",    64'(axi_o.arready), 64'd1);
        chk("basic_level_end",  64'(fifo_level_o),  64'd0);
        chk_beats("basic_beats");

        // Short packet: 2 data beats then 3 SLVERR pad beats.
        push_word(32'hB0, 1'b0);
        push_word(32'hB1, 1'b1);
        ar(4'd1, 8'd4);
        beat("short0", 32'hB0, RESP_OKAY, 4'd1, 1'b0);
        beat("short1", 32'hB1, RESP_OKAY, 4'd1, 1'b0);
        for (int i = 2; i < 5; i++) beat($sformatf("short%0d", i), 32'h0, RESP_SLVERR, 4'd1, i == 4);
        chk("short_rvalid_end", 64'(axi_o.rvalid), 64'd0);
        chk_beats("short_beats");

        // Backpressure: rready toggles, data must hold while stalled.
        push_word(32'hC0, 1'b0);
        push_word(32'hC1, 1'b0);
        push_word(32'hC2, 1'b1);
        axi_i.rready = 1'b0;
        ar(4'd2, 8'd2);
        for (int i = 0; i < 3; i++) begin
            axi_i.rready = 1'b0;
            tick();
            chk($sformatf("bp%0d_stall_rvalid", i), 64'(axi_o.rvalid), 64'd1);
            chk($sformatf("bp%0d_stall_rdata", i),  64'(axi_o.rdata),  64'hC0 + 64'(i));
            $display("stall %0d: rdata=%0h", i, axi_o.rdata);
            beat($sformatf("bp%0d", i), 32'hC0 + 32'(i), RESP_OKAY, 4'd2, i == 2);
        end
        chk("bp_rvalid_end", 64'(axi_o.rvalid), 64'd0);

        // Starvation: FIFO drains mid-burst, rvalid drops until next push.
        push_word(32'hD0, 1'b0);
        ar(4'd4, 8'd1);
        beat("starve0", 32'hD0, RESP_OKAY, 4'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("starve_gap%0d", i), 64'(axi_o.rvalid), 64'd0);
            tick();
        end
        push_word(32'hD1, 1'b1);
        beat("starve1", 32'hD1, RESP_OKAY, 4'd4, 1'b1);
        chk_beats("starve_beats");

        // FIFO full: 16 words, then a push attempt blocked during the pop cycle.
        for (int i = 0; i < 16; i++) push_word(32'hE0 + 32'(i), 1'b0);
        chk("full_tready", 64'(s_tready_o),   64'd0);
        chk("full_level",  64'(fifo_level_o), 64'd16);
        s_tvalid_i = 1'b1;
        s_tdata_i  = 32'h55;
        ar(4'd6, 8'd0);
        chk("full_level_hold", 64'(fifo_level_o), 64'd16);
        beat("full_pop", 32'hE0, RESP_OKAY, 4'd6, 1'b1);
        s_tvalid_i = 1'b0;
        chk("full_tready_back", 64'(s_tready_o),   64'd1);
        chk("full_level_after", 64'(fifo_level_o), 64'd15);

        // Write rejection with a concurrent read burst.
        axi_i.awvalid = 1'b1;
        axi_i.awid    = 4'd5;
        axi_i.arvalid = 1'b1;
        axi_i.arid    = 4'd7;
        axi_i.arlen   = 8'd2;
        tick();
        axi_i.awvalid = 1'b0;
        axi_i.arvalid = 1'b0;
        chk("wr_wready",  64'(axi_o.wready),  64'd1);
        chk("wr_awready", 64'(axi_o.awready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            axi_i.wvalid = 1'b1;
            axi_i.wlast  = (i == 2);
            axi_i.wdata  = $urandom;
            chk($sformatf("wr_bvalid_early%0d", i), 64'(axi_o.bvalid), 64'd0);
            beat($sformatf("wrrd%0d", i), 32'hE1 + 32'(i), RESP_OKAY, 4'd7, i == 2);
        end
        axi_i.wvalid = 1'b0;
        axi_i.wlast  = 1'b0;
        chk("wr_bvalid", 64'(axi_o.bvalid), 64'd1);
        chk("wr_bid",    64'(axi_o.bid),    64'd5);
        chk("wr_bresp",  64'(axi_o.bresp),  64'd2);
        chk("wr_rd_idle", 64'(axi_o.arready), 64'd1);
        $display("bresp: bid=%0d bresp=%0d", axi_o.bid, axi_o.bresp);
        tick();
        chk("wr_bvalid_hold", 64'(axi_o.bvalid), 64'd1);
        axi_i.bready = 1'b1;
        tick();
        axi_i.bready = 1'b0;
        chk("wr_bvalid_done", 64'(axi_o.bvalid),  64'd0);
        chk("wr_awready_end", 64'(axi_o.awready), 64'd1);
        chk_beats("wr_beats");

        // Reset during beat 2 of an 8-beat burst.
        chk("rst_mid_level", 64'(fifo_level_o), 64'd12);
        ar(4'd8, 8'd7);
        beat("rstb0", 32'hE4, RESP_OKAY, 4'd8, 1'b0);
        chk("rstb1_rdata", 64'(axi_o.rdata), 64'hE5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_beats = 0;
        chk("rst_mid_rvalid",  64'(axi_o.rvalid),  64'd0);
        chk("rst_mid_level0",  64'(fifo_level_o),  64'd0);
        chk("rst_mid_arready", 64'(axi_o.arready), 64'd1);
        chk_beats("rst_mid_beats");
        tick();
        chk("rst_mid_no_trail", 64'(axi_o.rvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_stream_read_responder.md
Name: axi_stream_read_responder

Overview:
AXI4 slave that answers DMA reader AR bursts with data drawn from an AXI-Stream input, buffered through an internal synchronous FIFO. It is the responder end of the DMA read channel, sitting between a packet source and the DMA controller's read master port. The write channels are present only for protocol completeness: every write is drained and answered with SLVERR.

Parameters:
FifoDepth, 16, stream buffer entries; power of two, at least 2.
DataWidth, top_pkg::AXI_DW, R and stream data width.
IdWidth, top_pkg::AXI_IW, AXI ID width (arid/rid/awid/bid).

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
axi_i  in  axi_pkg::axi_h2d_t  AR/AW/W channels plus rready/bready from the DMA master
axi_o  out  axi_pkg::axi_d2h_t  arready/awready/wready, R and B channels to the DMA master
s_tdata_i  in  DataWidth  stream data
s_tvalid_i  in  1  stream valid
s_tready_o  out  1  stream ready; equals FIFO not full
s_tlast_i  in  1  end of packet
fifo_level_o  out  $clog2(FifoDepth)+1  current FIFO occupancy
beat_count_o  out  32  returned R beats (see Optional Feature)

Behaviour:
- Clock is clock; reset is synchronous and active-high. All state is updated on the rising edge of clock.
- Reset values: arready=1, awready=1, wready=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0, bvalid=0, bresp=0, bid=0, s_tready_o=0 during reset, fifo_level_o=0, beat_count_o=0.
- FIFO: stores {tlast, tdata}. Push when s_tvalid_i && s_tready_o. Pop on an R handshake in R_DATA. Simultaneous push and pop when full: the pop frees a slot but s_tready_o is computed from the registered level only, so no push occurs that cycle. Simultaneous push and pop when non-full: level is unchanged.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch arid and arlen (8 bits), clear beat counter, go to R_DATA. araddr, arsize and arburst are ignored; every burst is treated as INCR from the stream head.
  - R_DATA: rvalid = FIFO not empty; rdata = FIFO head data; rresp=OKAY; rid = latched id; rlast = (cnt==arlen).
    - On rvalid&&rready: pop and increment cnt.
    - If that was the final beat, go to R_IDLE.
    - Otherwise, if the popped entry had tlast=1, go to R_PAD.
  - R_PAD: rvalid=1, rdata=0, rresp=SLVERR (2'b10); remaining beats are padded. rlast on cnt==arlen, then go to R_IDLE.
  - A burst ending before the stream tlast is legal: leftover stream data stays in the FIFO for the next AR.
- Latency: AR accepted to first rvalid is 1 cycle if the FIFO is non-empty. After that, one beat per cycle while data is available and rready is high.
- R outputs hold stable while rvalid && !rready. rvalid is never withdrawn without a handshake.
- Write FSM:
  - W_IDLE: awready=1. On awvalid, latch awid and go to W_DATA.
  - W_DATA: wready=1; discard data until wlast, then go to W_RESP.
  - W_RESP: bvalid=1, bresp=SLVERR, bid=latched id; on bready, go to W_IDLE.
- The read and write FSMs are independent and may be active in the same cycle.
- Reset mid-burst: both FSMs return to idle, the FIFO is flushed, and no trailing beat is emitted.

Optional Feature:
AXI_RD_RESP_STATS_EN:
- Defined: beat_count_o counts every R handshake, including pad beats, and wraps at 2^32. It is cleared by reset.
- Undefined: beat_count_o is tied to 0 and the counter logic is not built.

Decomposition:
- Package axi_stream_read_responder_pkg holds:
  - rd_state_e {R_IDLE, R_DATA, R_PAD} and wr_state_e {W_IDLE, W_DATA, W_RESP}.
  - Constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - The fifo entry struct {last, data}.
- Sub-module stream_fifo_sync: parameterised depth/width synchronous FIFO with push/pop, full/empty and level outputs, reset on the same clock/reset.

Test Plan:
- Basic burst: push 4 words 0xA0..0xA3 with tlast on 0xA3; AR arid=3 arlen=3 with rready=1 -> 4 beats 0xA0..0xA3, all OKAY, rid=3, rlast on beat 4, and the first beat one cycle after AR.
- Short packet: push 2 words with tlast on the 2nd; AR arlen=4 -> 0xB0, 0xB1 OKAY, then 3 zero beats with SLVERR, rlast on beat 5.
- Backpressure and starvation:
  - Toggle rready 1/0 each cycle -> rdata stays stable while stalled.
  - Empty FIFO mid-burst -> rvalid=0 until the next push.
- FIFO full: push 16 words with no AR -> s_tready_o=0 and fifo_level_o=16. One R pop -> s_tready_o returns to 1 the following cycle.
- Write rejection: AW awid=5, then 3 W beats with wlast on the 3rd -> B returns bid=5, bresp=2'b10. An AR burst running concurrently completes unaffected.
- Reset mid-burst: assert reset during beat 2 of arlen=7 -> the next cycle has rvalid=0, fifo_level_o=0, arready=1. With AXI_RD_RESP_STATS_EN defined, beat_count_o=0.
